// File: rtl/rv_ctl_mw.sv
// Multicycle RISC-V control FSM: sequences fetch/decode/execute/writeback,
// waits MEM_LAT cycles per memory access and counts retired instructions.
module rv_ctl_mw #(
   parameter int unsigned MEM_LAT   = 2,
   parameter bit          TRAP_HALT = 1'b0,
   parameter int unsigned CNT_W     = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      instr,
   input  logic             zero,
   output logic             memrw,
   output logic             pcsourse,
   output logic             pcwrite,
   output logic             pccen,
   output logic             irwrite,
   output logic             mdrwrite,
   output logic             regwen,
   output logic [1:0]       wbsel,
   output logic [1:0]       immsel,
   output logic [1:0]       asel,
   output logic             bsel,
   output logic [3:0]       alusel,
   output logic             illegal,
   output logic             halted,
   output logic [CNT_W-1:0] instret
);

   localparam logic       PC_INC    = 1'b0;
   localparam logic       PC_ALU    = 1'b1;
   localparam logic [1:0] WB_PC     = 2'd0;
   localparam logic [1:0] WB_ALUOUT = 2'd1;
   localparam logic [1:0] WB_MDR    = 2'd2;
   localparam logic [1:0] IMM_B     = 2'd0;
   localparam logic [1:0] IMM_L     = 2'd1;
   localparam logic [1:0] IMM_S     = 2'd2;
   localparam logic [1:0] IMM_J     = 2'd3;
   localparam logic [1:0] ALUA_REG  = 2'd0;
   localparam logic [1:0] ALUA_PCC  = 2'd1;
   localparam logic       ALUB_REG  = 1'b0;
   localparam logic       ALUB_IMM  = 1'b1;
   localparam logic [3:0] ALU_ADD   = 4'b0000;
   localparam logic [3:0] ALU_SUB   = 4'b0001;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [3:0] LAT = MEM_LAT[3:0];

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_LSW_ADDR, S_LW_MEM, S_LW_WB, S_SW_MEM, S_RTYPE_ALU,
      S_RTYPE_WB, S_ITYPE_ALU, S_BR_EXEC, S_JAL_EXEC, S_ILLEGAL, S_HALT
   } state_t;

   state_t     state, nxt;
   logic [3:0] wait_cnt, cnt_nxt;
   logic       run;
   logic       retire;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       unused_instr;

   assign opcode       = instr[6:0];
   assign funct3       = instr[14:12];
   assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

   // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
   always_comb begin
      nxt      = state;
      cnt_nxt  = wait_cnt;
      retire   = 1'b0;
      memrw    = 1'b0;
      pcsourse = PC_INC;
      pcwrite  = 1'b0;
      pccen    = 1'b0;
      irwrite  = 1'b0;
      mdrwrite = 1'b0;
      regwen   = 1'b0;
      wbsel    = WB_PC;
      immsel   = IMM_B;
      asel     = ALUA_REG;
      bsel     = ALUB_REG;
      alusel   = ALU_ADD;
      illegal  = 1'b0;
      halted   = 1'b0;

      case (state)
         S_FETCH: begin
            if (wait_cnt != 4'd0) begin
               cnt_nxt = wait_cnt - 4'd1;
            end else begin
               irwrite = 1'b1;
               pccen   = 1'b1;
               pcwrite = 1'b1;
               cnt_nxt = LAT;
               nxt     = S_DECODE;
            end
         end
         S_DECODE: begin
            // Speculative branch target PCC+imm_b; the ALU result is latched for BR_EXEC.
            asel   = ALUA_PCC;
            bsel   = ALUB_IMM;
            immsel = IMM_B;
            case (opcode)
               OP_LW:   nxt = (funct3 == 3'b010) ? S_LSW_ADDR : S_ILLEGAL;
               OP_SW:   nxt = (funct3 == 3'b010) ? S_LSW_ADDR : S_ILLEGAL;
               OP_R:    nxt = S_RTYPE_ALU;
               OP_I:    nxt = S_ITYPE_ALU;
               OP_BR:   nxt = (funct3[2:1] == 2'b00) ? S_BR_EXEC : S_ILLEGAL;
               OP_JAL:  nxt = S_JAL_EXEC;
               default: nxt = S_ILLEGAL;
            endcase
         end
         S_LSW_ADDR: begin
            bsel   = ALUB_IMM;
            immsel = (opcode == OP_SW) ? IMM_S : IMM_L;
            nxt    = (opcode == OP_SW) ? S_SW_MEM : S_LW_MEM;
         end
         S_LW_MEM: begin
            if (wait_cnt != 4'd0) begin
               cnt_nxt = wait_cnt - 4'd1;
            end else begin
               mdrwrite = 1'b1;
               cnt_nxt  = LAT;
               nxt      = S_LW_WB;
            end
         end
         S_LW_WB: begin
            wbsel  = WB_MDR;
            regwen = 1'b1;
            retire = 1'b1;
            nxt    = S_FETCH;
         end
         S_SW_MEM: begin
            memrw = 1'b1;
            if (wait_cnt != 4'd0) begin
               cnt_nxt = wait_cnt - 4'd1;
            end else begin
               cnt_nxt = LAT;
               retire  = 1'b1;
               nxt     = S_FETCH;
            end
         end
         S_RTYPE_ALU: begin
            alusel = {funct3, instr[30]};
            nxt    = S_RTYPE_WB;
         end
         S_ITYPE_ALU: begin
            // Only the shift group (SRLI/SRAI) takes instr[30]; for the rest it is immediate data.
            bsel   = ALUB_IMM;
            immsel = IMM_L;
            alusel = {funct3, (funct3 == 3'b101) & instr[30]};
            nxt    = S_RTYPE_WB;
         end
         S_RTYPE_WB: begin
            wbsel  = WB_ALUOUT;
            regwen = 1'b1;
            retire = 1'b1;
            nxt    = S_FETCH;
         end
         S_BR_EXEC: begin
            alusel   = ALU_SUB;
            pcsourse = PC_ALU;
            pcwrite  = funct3[0] ? ~zero : zero;
            retire   = 1'b1;
            nxt      = S_FETCH;
         end
         S_JAL_EXEC: begin
            immsel   = IMM_J;
            asel     = ALUA_PCC;
            bsel     = ALUB_IMM;
            pcsourse = PC_ALU;
            pcwrite  = 1'b1;
            regwen   = 1'b1;
            wbsel    = WB_PC;
            retire   = 1'b1;
            nxt      = S_FETCH;
         end
         S_ILLEGAL: begin
            illegal = 1'b1;
            nxt     = TRAP_HALT ? S_HALT : S_FETCH;
         end
         S_HALT: begin
            halted = 1'b1;
         end
         default: begin
            nxt     = S_FETCH;
            cnt_nxt = LAT;
         end
      endcase

      // run clears asynchronously with rst_n, so no strobe survives a reset edge.
      if (!run) begin
         memrw    = 1'b0;
         pcwrite  = 1'b0;
         pccen    = 1'b0;
         irwrite  = 1'b0;
         mdrwrite = 1'b0;
         regwen   = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_FETCH;
         wait_cnt <= LAT;
         instret  <= '0;
         run      <= 1'b0;
      end else begin
         run <= 1'b1;
         if (run) begin
            state    <= nxt;
            wait_cnt <= cnt_nxt;
            if (retire) begin
               instret <= instret + CNT_W'(1);
            end
         end
      end
   end

endmodule
